input_debouncer: RTL



---
 rtl/input_debouncer_pkg.sv | 12 +
 rtl/debounce_channel.sv | 93 +++++++++
 rtl/input_debouncer.sv | 36 +++
 3 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the multi-channel input debouncer: FSM state
// encoding and the standard debounce-window lengths.
package input_debouncer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    // 1 ms at 50 MHz on the board; a short window keeps simulations fast.
    localparam int CNT_MAX_BOARD = 50000;
    localparam int CNT_MAX_SIM   = 4;

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: 2-flop synchroniser, bounce counter and a two-state
// FSM that accepts a new level after CNT_MAX consecutive mismatching edges.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int         CNT_MAX     = CNT_MAX_BOARD,
    parameter int         CNT_W       = 16,
    parameter logic [0:0] RESET_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q, s2_q;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch;

    assign mismatch = (s2_q != level_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_COUNT: begin
                if (!mismatch) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Pulses are registered so they line up with the new level.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= RESET_LEVEL;
            s2_q    <= RESET_LEVEL;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign busy_o  = (state_q == ST_COUNT);

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch/button conditioner: WIDTH independent debounce
// channels producing clean levels plus one-cycle rise/fall pulses.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int         WIDTH       = 2,
    parameter int         CNT_MAX     = CNT_MAX_BOARD,
    parameter int         CNT_W       = 16,
    parameter logic [0:0] RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic [WIDTH-1:0] busy_out
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .CNT_MAX     (CNT_MAX),
            .CNT_W       (CNT_W),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .raw_i   (raw_in[g]),
            .level_o (level_out[g]),
            .rise_o  (rise_out[g]),
            .fall_o  (fall_out[g]),
            .busy_o  (busy_out[g])
        );
    end

endmodule
